// File: rtl/sub_nbit_serial.sv
// Bit-serial subtractor: diff = (x - y - b_in) mod 2^N, LSB first, one full-subtractor cell.
// Latency N+1 edges from accept to done; start is ignored while busy (no queuing, no backpressure).
module sub_nbit_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         b_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   x_sh_q, x_sh_d;
  logic [N-1:0]   y_sh_q, y_sh_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           br_q, br_d;
  logic           b_out_q, b_out_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic a_bit, b_bit, d_bit, br_nxt;

  always_comb begin
    a_bit  = x_sh_q[0];
    b_bit  = y_sh_q[0];
    d_bit  = a_bit ^ b_bit ^ br_q;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    state_d = state_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    b_out_d = b_out_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          x_sh_d  = x;
          y_sh_d  = y;
          br_d    = b_in;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        x_sh_d       = x_sh_q >> 1;
        y_sh_d       = y_sh_q >> 1;
        res_d        = res_q >> 1;
        res_d[N-1]   = d_bit;
        br_d         = br_nxt;
        cnt_d        = cnt_q + CW'(1);
        // Last bit: publish the completed word including the bit formed this cycle.
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          diff_d  = res_d;
          b_out_d = br_nxt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_sh_q  <= '0;
      y_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      b_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_sh_q  <= x_sh_d;
      y_sh_q  <= y_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      b_out_q <= b_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign b_out = b_out_q;

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Scoreboard bench for sub_nbit_serial at N=1, N=4 and N=8 sharing one clock and reset.
module tb_sub_nbit_serial;

  localparam int NS [3] = '{1, 4, 8};

  logic       clk;
  logic       rst_n;
  logic       st [3];
  logic       bi [3];
  logic [7:0] xa [3];
  logic [7:0] ya [3];

  logic       busy1, done1, bo1;
  logic [0:0] d1;
  logic       busy4, done4, bo4;
  logic [3:0] d4;
  logic       busy8, done8, bo8;
  logic [7:0] d8;

  int nchk = 0;
  int nerr = 0;

  sub_nbit_serial #(.N(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .x(xa[0][0:0]), .y(ya[0][0:0]),
    .b_in(bi[0]), .busy(busy1), .done(done1), .diff(d1), .b_out(bo1)
  );
  sub_nbit_serial #(.N(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .x(xa[1][3:0]), .y(ya[1][3:0]),
    .b_in(bi[1]), .busy(busy4), .done(done4), .diff(d4), .b_out(bo4)
  );
  sub_nbit_serial #(.N(8)) u_n8 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .x(xa[2]), .y(ya[2]),
    .b_in(bi[2]), .busy(busy8), .done(done8), .diff(d8), .b_out(bo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  int q0[$], q1[$], q2[$];

  function automatic void push_exp(input int i, input int v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic int pop_exp(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void clear_q(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endfunction

  // Reference model: cycles remaining until IDLE, plus the last published result.
  int rem    [3] = '{0, 0, 0};
  int last_d [3] = '{0, 0, 0};
  int last_b [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int m, e, act_busy, act_done, act_diff, act_bo;
      bit exp_busy, exp_done;
      m = (1 << NS[i]) - 1;
      case (i)
        0:       begin act_busy = int'(busy1); act_done = int'(done1); act_diff = int'(d1); act_bo = int'(bo1); end
        1:       begin act_busy = int'(busy4); act_done = int'(done4); act_diff = int'(d4); act_bo = int'(bo4); end
        default: begin act_busy = int'(busy8); act_done = int'(done8); act_diff = int'(d8); act_bo = int'(bo8); end
      endcase
      if (!rst_n) begin
        rem[i]    = 0;
        last_d[i] = 0;
        last_b[i] = 0;
        exp_busy  = 1'b0;
        exp_done  = 1'b0;
        clear_q(i);
      end else begin
        if (rem[i] > 0) rem[i]--;
        exp_busy = (rem[i] > 0);
        exp_done = (rem[i] == 1);
        if (exp_done) begin
          if (qsize(i) > 0) begin
            e         = pop_exp(i);
            last_d[i] = e & m;
            last_b[i] = (e < 0) ? 1 : 0;
          end else begin
            chk($sformatf("scoreboard_underflow[N=%0d]", NS[i]), 1, 0);
          end
        end
        if (rem[i] == 0 && st[i]) begin
          e = (int'(xa[i]) & m) - (int'(ya[i]) & m) - int'(bi[i]);
          push_exp(i, e);
          rem[i] = NS[i] + 2;
        end
      end
      chk($sformatf("busy[N=%0d]", NS[i]), act_busy, int'(exp_busy));
      chk($sformatf("done[N=%0d]", NS[i]), act_done, int'(exp_done));
      chk($sformatf("diff[N=%0d]", NS[i]), act_diff, last_d[i]);
      chk($sformatf("b_out[N=%0d]", NS[i]), act_bo, last_b[i]);
    end
  end

  task automatic run_op(input int i, input int xv, input int yv, input int bv);
    @(posedge clk);
    #1;
    st[i] = 1'b1;
    xa[i] = 8'(xv);
    ya[i] = 8'(yv);
    bi[i] = bv[0];
    @(posedge clk);
    #1;
    st[i] = 1'b0;
    xa[i] = 8'($urandom);
    ya[i] = 8'($urandom);
    bi[i] = 1'($urandom);
    repeat (NS[i] + 1) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      bi[i] = 1'b0;
      xa[i] = '0;
      ya[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(1, 9, 3, 0);
    run_op(1, 3, 9, 0);
    run_op(1, 0, 0, 1);
    run_op(1, 5, 5, 0);

    // Start held continuously while operands churn every cycle.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      st[1] = 1'b1;
      xa[1] = 8'($urandom);
      ya[1] = 8'($urandom);
      bi[1] = 1'($urandom);
    end
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (8) @(posedge clk);

    // Reset two cycles into an operation.
    @(posedge clk);
    #1;
    st[1] = 1'b1;
    xa[1] = 8'd15;
    ya[1] = 8'd1;
    bi[1] = 1'b0;
    @(posedge clk);
    #1 st[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(1, 7, 2, 1);

    fork
      begin
        for (int xv = 0; xv < 16; xv++)
          for (int yv = 0; yv < 16; yv++)
            for (int bv = 0; bv < 2; bv++)
              run_op(1, xv, yv, bv);
      end
      begin
        for (int v = 0; v < 8; v++)
          run_op(0, (v >> 2) & 1, (v >> 1) & 1, v & 1);
      end
      begin
        for (int k = 0; k < 60; k++)
          run_op(2, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      end
    join

    repeat (12) @(posedge clk);
    chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
